uart_dual_fifo_mmio: RTL and testbench
======================================

UART_DUAL_FIFO_MMIO -- requirements
Module: uart_dual_fifo_mmio

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 16: TX FIFO depth in bytes; power of 2, minimum 2.
REQ-002 SHALL have parameter RX_DEPTH, default 16: RX FIFO depth in bytes; power of 2, minimum 2.
REQ-003 SHALL have parameter TX_AW, default 4: log2(TX_DEPTH).
REQ-004 SHALL have parameter RX_AW, default 4: log2(RX_DEPTH).
REQ-005 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- bus_addr  in  4  byte offset: 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC IRQ.
- bus_wen  in  1  write strobe; level, may be held.
- bus_ren  in  1  read strobe; level, may be held.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data.
- req_valid  out  1  TX FIFO not empty.
- req_data  out  8  TX FIFO head byte.
- req_accept  in  1  one-cycle pulse when uart_tx starts a byte.
- tx_busy  in  1  uart_tx busy.
- rx_valid  in  1  one-cycle pulse: uart_rx byte ready.
- rx_data  in  8  received byte.
- irq  out  1  level interrupt.

Function
REQ-006 SHALL act on bus_wen/bus_ren only on the rising edge (strobe high, previous cycle low); a held strobe acts once.
REQ-007 Write to DATA SHALL push bus_wdata[7:0] into the TX FIFO; if full, drop the byte and set sticky TX_OVF.
REQ-008 Read of DATA SHALL return {24'b0, RX head} and pop the RX FIFO; if empty, return 0, no pop, set sticky RX_UNF.
REQ-009 bus_rdata SHALL be registered: valid the cycle after the read edge, held until the next read edge.
REQ-010 STATUS SHALL read: bit0 tx_busy; bit1 tx_empty; bit2 tx_full; bit3 rx_empty; bit4 rx_full; [15:8] tx_count; [23:16] rx_count; counts zero-extended, all else 0.
REQ-011 CTRL SHALL hold: bit0 tx_empty_ie; bit1 rx_avail_ie; bit2 ovf_ie; all read back. Bit8 tx_flush and bit9 rx_flush are self-clearing: pointers/counts zeroed the next cycle; they read 0.
REQ-012 IRQ SHALL read: bit0 TX_OVF; bit1 RX_OVF; bit2 RX_UNF. Writing 1 clears a bit (W1C); writing 0 has no effect.
REQ-013 TX pop SHALL occur when req_accept=1 and TX is not empty; req_accept while empty SHALL be ignored.
REQ-014 rx_valid SHALL push rx_data into the RX FIFO; if full, drop the byte and set sticky RX_OVF.
REQ-015 Push and pop in the same cycle on one FIFO SHALL leave count unchanged and both succeed. This applies even when the FIFO is full: the pop frees a slot and the push is accepted, no overflow.
REQ-016 A flush in the same cycle as a push or pop SHALL take priority; the FIFO is empty afterwards.
REQ-017 Pointers SHALL wrap modulo depth. Count width SHALL be AW+1 and SHALL reach DEPTH exactly.
REQ-018 req_valid/req_data SHALL be combinational from TX state; req_data is don't-care when req_valid=0.
REQ-019 irq SHALL equal (tx_empty_ie & tx_empty) | (rx_avail_ie & !rx_empty) | (ovf_ie & |IRQ[2:0]).
REQ-020 Unmapped offsets SHALL read 0 and ignore writes.

Reset
REQ-021 On rst_n=0 at a clock edge: pointers, counts, CTRL, IRQ, edge-detect registers, bus_rdata =0; hence req_valid=0 and irq=0.
REQ-022 Reset mid-operation SHALL discard all FIFO contents.
REQ-023 FIFO memory SHALL NOT be reset.

Structure
REQ-024 Package uart_mmio_pkg SHALL hold register offsets, STATUS/CTRL/IRQ bit positions and the default depth.
REQ-025 One sub-module, sync_fifo, SHALL be instantiated twice. Its parameters are DEPTH, AW, W=8; its ports are push, pop, flush, din, dout, count, full, empty.

Verification
REQ-026 Reset, then write DATA 0x41 held 5 cycles -> tx_count=1, req_valid=1, req_data=0x41; req_accept pulse -> req_valid=0.
REQ-027 17 write edges to DATA with TX_DEPTH=16 -> tx_full=1, tx_count=16, IRQ bit0=1; write 0x1 to IRQ -> bit0=0.
REQ-028 TX full, and write edge plus req_accept in the same cycle -> tx_count stays 16, TX_OVF stays 0.
REQ-029 rx_valid with 0x5A, rx_avail_ie=1 -> irq=1; read DATA -> bus_rdata=0x5A next cycle, rx_empty=1, irq=0.
REQ-030 Read DATA with RX empty -> bus_rdata=0, IRQ bit2=1. Write CTRL bit8 with 3 bytes queued -> tx_count=0 next cycle.
REQ-031 Assert rst_n=0 mid-stream with 5 bytes in each FIFO -> all counts 0, irq=0, req_valid=0 after one clock.

Source files
------------

// File: rtl/uart_dual_fifo_mmio_pkg.sv
// Register map and bit positions shared by the UART dual-FIFO MMIO block and its bench.
package uart_mmio_pkg;

    localparam int unsigned DEFAULT_DEPTH = 16;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;
    localparam logic [3:0] ADDR_IRQ    = 4'hC;

    localparam int unsigned ST_TX_BUSY  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_TX_FULL  = 2;
    localparam int unsigned ST_RX_EMPTY = 3;
    localparam int unsigned ST_RX_FULL  = 4;
    localparam int unsigned ST_TX_CNT   = 8;
    localparam int unsigned ST_RX_CNT   = 16;

    localparam int unsigned CTRL_TX_EMPTY_IE = 0;
    localparam int unsigned CTRL_RX_AVAIL_IE = 1;
    localparam int unsigned CTRL_OVF_IE      = 2;
    localparam int unsigned CTRL_TX_FLUSH    = 8;
    localparam int unsigned CTRL_RX_FLUSH    = 9;

    localparam int unsigned IRQ_TX_OVF = 0;
    localparam int unsigned IRQ_RX_OVF = 1;
    localparam int unsigned IRQ_RX_UNF = 2;

endpackage

// File: rtl/uart_dual_fifo_mmio_if.sv
// Register bus between a CPU-side master and the UART dual-FIFO MMIO block.
interface uart_dual_fifo_mmio_if;
    logic [3:0]  bus_addr;
    logic        bus_wen;
    logic        bus_ren;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (output bus_addr, output bus_wen, output bus_ren, output bus_wdata,
                    input bus_rdata);
    modport slave  (input bus_addr, input bus_wen, input bus_ren, input bus_wdata,
                    output bus_rdata);
endinterface

// File: rtl/uart_dual_fifo_mmio_sync_fifo.sv
// Single-clock FIFO; a pop frees a slot for a same-cycle push, flush overrides both.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);
    localparam logic [AW-1:0] PtrOne = 1;
    localparam logic [AW:0]   CntOne = 1;
    localparam logic [AW:0]   CntMax = DEPTH[AW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntMax);
    assign count   = count_q;
    assign dout    = mem_q[rptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrOne;
            if (do_pop)  rptr_q <= rptr_q + PtrOne;
            if (do_push && !do_pop)      count_q <= count_q + CntOne;
            else if (do_pop && !do_push) count_q <= count_q - CntOne;
        end
    end

    // Storage carries no reset; stale bytes are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/uart_dual_fifo_mmio.sv
// Memory-mapped UART front end: TX/RX byte FIFOs, status, control and sticky error flags.
module uart_dual_fifo_mmio
    import uart_mmio_pkg::*;
#(
    parameter int unsigned TX_DEPTH = DEFAULT_DEPTH,
    parameter int unsigned RX_DEPTH = DEFAULT_DEPTH,
    parameter int unsigned TX_AW    = 4,
    parameter int unsigned RX_AW    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_dual_fifo_mmio_if.slave  bus,
    output logic                  req_valid,
    output logic [7:0]            req_data,
    input  logic                  req_accept,
    input  logic                  tx_busy,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  irq
);
    logic        wen_q, ren_q, wen_edge, ren_edge;
    logic        sel_data, sel_status, sel_ctrl, sel_irq;
    logic [2:0]  ctrl_q, ctrl_d, irq_q, irq_d, irq_set;
    logic [31:0] rdata_q, rdata_d, status;
    logic        tx_push, tx_flush, tx_full, tx_empty;
    logic        rx_pop, rx_flush, rx_full, rx_empty;
    logic [7:0]  tx_dout, rx_dout;
    logic [TX_AW:0] tx_count;
    logic [RX_AW:0] rx_count;
    logic        unused_wdata;

    assign unused_wdata = ^bus.bus_wdata[31:10];

    assign wen_edge   = bus.bus_wen & ~wen_q;
    assign ren_edge   = bus.bus_ren & ~ren_q;
    assign sel_data   = (bus.bus_addr == ADDR_DATA);
    assign sel_status = (bus.bus_addr == ADDR_STATUS);
    assign sel_ctrl   = (bus.bus_addr == ADDR_CTRL);
    assign sel_irq    = (bus.bus_addr == ADDR_IRQ);

    assign tx_push  = wen_edge & sel_data;
    assign tx_flush = wen_edge & sel_ctrl & bus.bus_wdata[CTRL_TX_FLUSH];
    assign rx_pop   = ren_edge & sel_data;
    assign rx_flush = wen_edge & sel_ctrl & bus.bus_wdata[CTRL_RX_FLUSH];

    sync_fifo #(.DEPTH(TX_DEPTH), .AW(TX_AW), .W(8)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (req_accept),
        .flush (tx_flush),
        .din   (bus.bus_wdata[7:0]),
        .dout  (tx_dout),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(.DEPTH(RX_DEPTH), .AW(RX_AW), .W(8)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_valid),
        .pop   (rx_pop),
        .flush (rx_flush),
        .din   (rx_data),
        .dout  (rx_dout),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign req_valid = ~tx_empty;
    assign req_data  = tx_dout;
    assign irq = (ctrl_q[CTRL_TX_EMPTY_IE] & tx_empty) | (ctrl_q[CTRL_RX_AVAIL_IE] & ~rx_empty)
               | (ctrl_q[CTRL_OVF_IE] & (|irq_q));

    always_comb begin
        status                 = '0;
        status[ST_TX_BUSY]     = tx_busy;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_TX_FULL]     = tx_full;
        status[ST_RX_EMPTY]    = rx_empty;
        status[ST_RX_FULL]     = rx_full;
        status[ST_TX_CNT +: 8] = 8'(tx_count);
        status[ST_RX_CNT +: 8] = 8'(rx_count);
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        irq_set = '0;
        rdata_d = rdata_q;
        // A pop on a full FIFO makes room, so only an unmatched push overflows.
        irq_set[IRQ_TX_OVF] = tx_push & tx_full & ~req_accept & ~tx_flush;
        irq_set[IRQ_RX_OVF] = rx_valid & rx_full & ~rx_pop & ~rx_flush;
        irq_set[IRQ_RX_UNF] = rx_pop & rx_empty;
        irq_d = irq_q;
        if (wen_edge && sel_ctrl) ctrl_d = bus.bus_wdata[2:0];
        if (wen_edge && sel_irq)  irq_d  = irq_q & ~bus.bus_wdata[2:0];
        irq_d = irq_d | irq_set;
        if (ren_edge) begin
            if (sel_data)        rdata_d = rx_empty ? 32'h0 : {24'h0, rx_dout};
            else if (sel_status) rdata_d = status;
            else if (sel_ctrl)   rdata_d = {29'h0, ctrl_q};
            else if (sel_irq)    rdata_d = {29'h0, irq_q};
            else                 rdata_d = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            ctrl_q  <= '0;
            irq_q   <= '0;
            rdata_q <= '0;
        end else begin
            wen_q   <= bus.bus_wen;
            ren_q   <= bus.bus_ren;
            ctrl_q  <= ctrl_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.bus_rdata = rdata_q;

endmodule

// File: tb/tb_uart_dual_fifo_mmio.sv
// Directed bench with a queue-based reference model checked every cycle plus literal spot checks.
module tb_uart_dual_fifo_mmio;

    localparam int TXD = 16;
    localparam int RXD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid, irq;
    logic [7:0] req_data;
    logic       req_accept = 1'b0;
    logic       tx_busy = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h0;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    uart_dual_fifo_mmio_if bus ();

    uart_dual_fifo_mmio #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .TX_AW(4), .RX_AW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_accept (req_accept),
        .tx_busy    (tx_busy),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model: byte queues, register shadows and expected read data.
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [2:0]  m_ctrl = '0;
    logic [2:0]  m_irq = '0;
    logic [31:0] m_rdata = '0;
    bit          m_wen_p = 0, m_ren_p = 0;

    function automatic logic [31:0] m_status(int txn, int rxn, logic busy);
        logic [31:0] s;
        s = {8'h0, 8'(rxn), 8'(txn), 3'b0, rxn == RXD, rxn == 0, txn == TXD, txn == 0, busy};
        return s;
    endfunction

    function automatic logic m_irq_out();
        return (m_ctrl[0] && tx_q.size() == 0) || (m_ctrl[1] && rx_q.size() != 0)
            || (m_ctrl[2] && m_irq != 0);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            tx_q.delete();
            rx_q.delete();
            m_ctrl = '0; m_irq = '0; m_rdata = '0; m_wen_p = 0; m_ren_p = 0;
        end else begin
            bit we, re, txfl, rxfl;
            int txn, rxn;
            logic [2:0] set, clr;
            logic [7:0] dummy;
            we = bus.bus_wen && !m_wen_p;
            re = bus.bus_ren && !m_ren_p;
            txn = tx_q.size();
            rxn = rx_q.size();
            set = '0;
            clr = '0;
            txfl = we && bus.bus_addr == 4'h8 && bus.bus_wdata[8];
            rxfl = we && bus.bus_addr == 4'h8 && bus.bus_wdata[9];
            if (re) begin
                case (bus.bus_addr)
                    4'h0: if (rxn == 0) begin m_rdata = 0; set[2] = 1; end
                          else m_rdata = {24'h0, rx_q[0]};
                    4'h4: m_rdata = m_status(txn, rxn, tx_busy);
                    4'h8: m_rdata = {29'h0, m_ctrl};
                    4'hC: m_rdata = {29'h0, m_irq};
                    default: m_rdata = 0;
                endcase
            end
            if (txfl) tx_q.delete();
            else begin
                if (req_accept && txn > 0) dummy = tx_q.pop_front();
                if (we && bus.bus_addr == 4'h0) begin
                    if (tx_q.size() < TXD) tx_q.push_back(bus.bus_wdata[7:0]);
                    else set[0] = 1;
                end
            end
            if (rxfl) rx_q.delete();
            else begin
                if (re && bus.bus_addr == 4'h0 && rxn > 0) dummy = rx_q.pop_front();
                if (rx_valid) begin
                    if (rx_q.size() < RXD) rx_q.push_back(rx_data);
                    else set[1] = 1;
                end
            end
            if (we && bus.bus_addr == 4'h8) m_ctrl = bus.bus_wdata[2:0];
            if (we && bus.bus_addr == 4'hC) clr = bus.bus_wdata[2:0];
            m_irq = (m_irq & ~clr) | set;
            m_wen_p = bus.bus_wen;
            m_ren_p = bus.bus_ren;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_req_valid", {31'h0, req_valid}, {31'h0, tx_q.size() != 0});
            if (tx_q.size() != 0) check("model_req_data", {24'h0, req_data}, {24'h0, tx_q[0]});
            check("model_irq", {31'h0, irq}, {31'h0, m_irq_out()});
            check("model_rdata", bus.bus_rdata, m_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.bus_addr = a; bus.bus_wdata = d; bus.bus_wen = 1'b1;
        tick();
        bus.bus_wen = 1'b0;
        tick();
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        bus.bus_addr = a; bus.bus_ren = 1'b1;
        tick();
        check(name, bus.bus_rdata, exp);
        bus.bus_ren = 1'b0;
        tick();
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_valid = 1'b1; rx_data = d;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        bus.bus_addr = 4'h0; bus.bus_wen = 1'b0; bus.bus_ren = 1'b0; bus.bus_wdata = 32'h0;
        tick(); tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("rst_req_valid", {31'h0, req_valid}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_rdata", bus.bus_rdata, 32'h0);

        // Held write strobe acts once.
        bus.bus_addr = 4'h0; bus.bus_wdata = 32'h41; bus.bus_wen = 1'b1;
        repeat (5) tick();
        bus.bus_wen = 1'b0;
        tick();
        check("held_req_data", {24'h0, req_data}, 32'h41);
        rd_chk("held_status", 4'h4, 32'h0000_0108);
        req_accept = 1'b1; tick(); req_accept = 1'b0;
        check("accept_req_valid", {31'h0, req_valid}, 32'h0);

        // Overfill TX.
        for (int i = 0; i < 17; i++) bus_write(4'h0, i);
        rd_chk("txfull_status", 4'h4, 32'h0000_100C);
        rd_chk("txovf_irq", 4'hC, 32'h1);
        bus_write(4'hC, 32'h1);
        rd_chk("txovf_cleared", 4'hC, 32'h0);

        // Push and pop together on a full TX FIFO.
        bus.bus_addr = 4'h0; bus.bus_wdata = 32'h77; bus.bus_wen = 1'b1; req_accept = 1'b1;
        tick();
        bus.bus_wen = 1'b0; req_accept = 1'b0;
        tick();
        check("pushpop_head", {24'h0, req_data}, 32'h01);
        rd_chk("pushpop_status", 4'h4, 32'h0000_100C);
        rd_chk("pushpop_no_ovf", 4'hC, 32'h0);

        // Flush with a few bytes queued.
        bus_write(4'h8, 32'h100);
        for (int i = 0; i < 3; i++) bus_write(4'h0, 32'hA1 + i);
        rd_chk("three_status", 4'h4, 32'h0000_0308);
        bus_write(4'h8, 32'h100);
        rd_chk("flush_status", 4'h4, 32'h0000_000A);
        rd_chk("flush_ctrl_rb", 4'h8, 32'h0);

        // RX available interrupt.
        bus_write(4'h8, 32'h2);
        check("rxie_idle_irq", {31'h0, irq}, 32'h0);
        rx_pulse(8'h5A);
        check("rxavail_irq", {31'h0, irq}, 32'h1);
        rd_chk("rx_data_5a", 4'h0, 32'h5A);
        check("rxdrain_irq", {31'h0, irq}, 32'h0);
        tx_busy = 1'b1;
        rd_chk("busy_status", 4'h4, 32'h0000_000B);
        tx_busy = 1'b0;

        // RX underflow and overflow-enable interrupt.
        rd_chk("rx_unf_data", 4'h0, 32'h0);
        rd_chk("rx_unf_irq", 4'hC, 32'h4);
        bus_write(4'h8, 32'h4);
        check("ovfie_irq", {31'h0, irq}, 32'h1);
        bus_write(4'hC, 32'h7);
        check("w1c_irq", {31'h0, irq}, 32'h0);

        // Overfill RX, then pop and push together while full.
        for (int i = 0; i < 17; i++) rx_pulse(8'h80 + 8'(i));
        tick();
        rd_chk("rxfull_status", 4'h4, 32'h0010_0012);
        rd_chk("rxovf_irq", 4'hC, 32'h2);
        bus_write(4'hC, 32'h2);
        bus.bus_addr = 4'h0; bus.bus_ren = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
        tick();
        check("rx_pushpop_data", bus.bus_rdata, 32'h80);
        bus.bus_ren = 1'b0; rx_valid = 1'b0;
        tick();
        rd_chk("rx_pushpop_no_ovf", 4'hC, 32'h0);
        rd_chk("rx_pushpop_status", 4'h4, 32'h0010_0012);
        bus_write(4'h2, 32'hFFFF_FFFF);
        rd_chk("unmapped_read", 4'h2, 32'h0);
        rd_chk("unmapped_no_write", 4'h8, 32'h4);

        // Reset mid-stream with five bytes in each FIFO.
        bus_write(4'h8, 32'h300);
        for (int i = 0; i < 5; i++) bus_write(4'h0, 32'h10 + i);
        for (int i = 0; i < 5; i++) rx_pulse(8'h20 + 8'(i));
        tick();
        bus_write(4'h8, 32'h3);
        check("pre_rst_irq", {31'h0, irq}, 32'h1);
        rd_chk("pre_rst_status", 4'h4, 32'h0005_0500);
        rst_n = 1'b0;
        tick();
        check("midrst_req_valid", {31'h0, req_valid}, 32'h0);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        check("midrst_rdata", bus.bus_rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        rd_chk("post_rst_status", 4'h4, 32'h0000_000A);

        tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
